// File: rtl/user_button_decoder_pkg.sv
// Shared types and constants for the user button decoder: event codes,
// classifier states and event buffer geometry.
package user_button_decoder_pkg;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_SHORT = 2'b01,
    EVT_LONG  = 2'b10
  } evt_code_e;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG_HELD
  } cls_state_e;

  localparam int EVT_DEPTH = 2;
  localparam int EVT_PTR_W = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam int EVT_CNT_W = $clog2(EVT_DEPTH + 1);

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [EVT_PTR_W-1:0] ptr_inc(input logic [EVT_PTR_W-1:0] ptr);
    return (ptr == EVT_PTR_W'(EVT_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/user_button_decoder_if.sv
// Event handshake between the decoder (producer) and its consumer.
interface user_button_decoder_if;
  import user_button_decoder_pkg::*;

  logic      event_valid;
  evt_code_e event_code;
  logic      event_ready;

  modport master (output event_valid, output event_code, input event_ready);
  modport slave  (input event_valid, input event_code, output event_ready);
endinterface

// File: rtl/user_button_decoder_button_debounce.sv
// Two-flop synchroniser, polarity normalisation and consecutive-cycle
// debounce for one raw button pin; btn_level is 1 while pressed.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 15650,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             level_q, level_d;
  logic             pressed;

  assign pressed   = sync_q[1] ^ ACTIVE_LOW;
  assign btn_level = level_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sync_d    = {sync_q[0], btn_raw};
    deb_cnt_d = '0;
    level_d   = level_q;
    if (pressed != level_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state is updated with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchroniser starts at the released pin level so reset never looks like a press.
      sync_q    <= {2{ACTIVE_LOW}};
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
    end
  end

endmodule

// File: rtl/user_button_decoder.sv
// Debounced push-button press classifier (SHORT/LONG) feeding a small
// event FIFO drained through a valid/ready handshake.
module user_button_decoder
  import user_button_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 15650,
  parameter int LONG_CYCLES     = 7825000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         user_btn0,
  output logic                         btn_level,
  output logic                         overflow,
  user_button_decoder_if.master        evt
);

  localparam int HOLD_W = $clog2(LONG_CYCLES);

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_debounce (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .btn_raw   (user_btn0),
    .btn_level (btn_level)
  );

  // Classifier
  cls_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              push;
  evt_code_e         push_code;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    push       = 1'b0;
    push_code  = EVT_NONE;
    unique case (state_q)
      IDLE: begin
        if (btn_level) begin
          state_d    = HELD;
          hold_cnt_d = '0;
        end
      end
      HELD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (!btn_level) begin
          push      = 1'b1;
          push_code = EVT_SHORT;
          state_d   = IDLE;
        end else if (hold_cnt_q == HOLD_W'(LONG_CYCLES - 1)) begin
          // LONG fires while still held; the later release is silent.
          push      = 1'b1;
          push_code = EVT_LONG;
          state_d   = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (!btn_level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Event FIFO
  evt_code_e            mem_q [EVT_DEPTH];
  evt_code_e            mem_d [EVT_DEPTH];
  logic [EVT_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EVT_CNT_W-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 valid, full, do_pop, do_push;

  assign valid   = (count_q != '0);
  assign full    = (count_q == EVT_CNT_W'(EVT_DEPTH));
  assign do_pop  = valid & evt.event_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & ~do_push);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      // NOTE: the buffer storage is reset too, so event_code is never X after reset.
      mem_q      <= '{default: EVT_NONE};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt.event_valid = valid;
  assign evt.event_code  = valid ? mem_q[rd_ptr_q] : EVT_NONE;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_user_button_decoder.sv
// Directed bench for user_button_decoder with DEBOUNCE_CYCLES=4, LONG_CYCLES=20;
// expected events are queued by the stimulus and compared by a monitor on pop.
module tb_user_button_decoder;
  import user_button_decoder_pkg::*;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic user_btn0;
  logic btn_level;
  logic overflow;

  user_button_decoder_if evt_if ();

  user_button_decoder #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .user_btn0 (user_btn0),
    .btn_level (btn_level),
    .overflow  (overflow),
    .evt       (evt_if)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q [$];
  logic [1:0] sb_exp;
  int         phase = 0;
  logic       glitch_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every accepted event against the queue head.
  always @(negedge sys_clk) begin
    if (sys_rst_n && evt_if.event_valid && evt_if.event_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_event: actual=%0h expected=none (t=%0t)",
                 evt_if.event_code, $time);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_event_code", evt_if.event_code, sb_exp);
      end
    end
  end

  always @(negedge sys_clk) begin
    if (phase == 2 && btn_level) glitch_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_level(input logic val, input int budget, input string name);
    int n = 0;
    @(negedge sys_clk);
    while (btn_level !== val && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check(name, btn_level, val);
  endtask

  // Press for low cycles, release, then idle for high cycles.
  task automatic short_press(input int low, input int high);
    @(posedge sys_clk); #1 user_btn0 = 1'b0;
    repeat (low) @(posedge sys_clk);
    #1 user_btn0 = 1'b1;
    repeat (high) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n          = 1'b0;
    user_btn0          = 1'b1;
    evt_if.event_ready = 1'b0;
    #2;
    check("rst_btn_level", btn_level, 0);
    check("rst_event_valid", evt_if.event_valid, 0);
    check("rst_event_code", evt_if.event_code, 0);
    check("rst_overflow", overflow, 0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    evt_if.event_ready = 1'b1;
    repeat (3) @(posedge sys_clk);

    // 1: clean short press, latency of level and event
    phase = 1;
    @(posedge sys_clk); #1 user_btn0 = 1'b0;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk) check("t1_level_before_6", btn_level, 0);
    @(posedge sys_clk);
    @(negedge sys_clk) check("t1_level_at_6", btn_level, 1);
    repeat (4) @(posedge sys_clk);
    #1 user_btn0 = 1'b1;
    exp_q.push_back(EVT_SHORT);
    wait_level(1'b0, 20, "t1_level_fall");
    check("t1_no_early_valid", evt_if.event_valid, 0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("t1_valid", evt_if.event_valid, 1);
    check("t1_code_short", evt_if.event_code, 2'b01);
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk) check("t1_drained", evt_if.event_valid, 0);

    // 2: 3-cycle glitches with 1-cycle gaps never pass the debouncer
    phase = 2;
    repeat (6) begin
      @(posedge sys_clk); #1 user_btn0 = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1 user_btn0 = 1'b1;
    end
    repeat (10) @(posedge sys_clk);
    phase = 0;
    @(negedge sys_clk);
    check("t2_level_stays_low", glitch_seen, 0);
    check("t2_no_event", evt_if.event_valid, 0);

    // 3: long press, LONG emitted while held, silent release
    @(posedge sys_clk); #1 user_btn0 = 1'b0;
    exp_q.push_back(EVT_LONG);
    repeat (26) @(posedge sys_clk);
    @(negedge sys_clk) check("t3_long_not_yet", evt_if.event_valid, 0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("t3_long_valid", evt_if.event_valid, 1);
    check("t3_long_code", evt_if.event_code, 2'b10);
    check("t3_still_held", btn_level, 1);
    repeat (13) @(posedge sys_clk);
    #1 user_btn0 = 1'b1;
    repeat (20) @(posedge sys_clk);
    @(negedge sys_clk);
    check("t3_released", btn_level, 0);
    check("t3_no_release_event", exp_q.size(), 0);

    // 4: three presses into a stalled buffer, third is dropped
    #1 evt_if.event_ready = 1'b0;
    exp_q.push_back(EVT_SHORT);
    exp_q.push_back(EVT_SHORT);
    repeat (3) short_press(8, 12);
    @(negedge sys_clk);
    check("t4_overflow", overflow, 1);
    check("t4_valid_full", evt_if.event_valid, 1);
    check("t4_head_code", evt_if.event_code, 2'b01);
    @(posedge sys_clk); #1 evt_if.event_ready = 1'b1;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    check("t4_empty_after_pops", evt_if.event_valid, 0);
    check("t4_code_none", evt_if.event_code, 0);
    check("t4_overflow_sticky", overflow, 1);
    check("t4_sb_drained", exp_q.size(), 0);

    // 6: reset mid-press clears everything; held pin is a new press
    #1 evt_if.event_ready = 1'b0;
    exp_q.push_back(EVT_SHORT);
    short_press(8, 12);
    @(negedge sys_clk) check("t6_buffered", evt_if.event_valid, 1);
    @(posedge sys_clk); #1 user_btn0 = 1'b0;
    repeat (12) @(posedge sys_clk);
    @(negedge sys_clk) check("t6_held_before_reset", btn_level, 1);
    #2 sys_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_btn_level", btn_level, 0);
    check("t6_rst_valid", evt_if.event_valid, 0);
    check("t6_rst_code", evt_if.event_code, 0);
    check("t6_rst_overflow", overflow, 0);
    repeat (2) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    evt_if.event_ready = 1'b1;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk) check("t6_level_before_6", btn_level, 0);
    @(posedge sys_clk);
    @(negedge sys_clk) check("t6_level_at_6", btn_level, 1);
    exp_q.push_back(EVT_SHORT);
    repeat (3) @(posedge sys_clk);
    #1 user_btn0 = 1'b1;
    wait_level(1'b0, 20, "t6_level_fall");
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("t6_restart_valid", evt_if.event_valid, 1);
    check("t6_restart_short", evt_if.event_code, 2'b01);
    repeat (5) @(posedge sys_clk);

    // 5: push coincides with pop while full: no drop, new event second
    #1 evt_if.event_ready = 1'b0;
    exp_q.push_back(EVT_SHORT);
    exp_q.push_back(EVT_SHORT);
    exp_q.push_back(EVT_LONG);
    repeat (2) short_press(8, 12);
    @(posedge sys_clk); #1 user_btn0 = 1'b0;
    repeat (26) @(posedge sys_clk);
    #1 evt_if.event_ready = 1'b1;
    @(posedge sys_clk);
    #1 evt_if.event_ready = 1'b0;
    @(negedge sys_clk);
    check("t5_no_drop", overflow, 0);
    check("t5_still_full", evt_if.event_valid, 1);
    repeat (2) @(posedge sys_clk);
    #1 user_btn0 = 1'b1;
    repeat (15) @(posedge sys_clk);
    @(negedge sys_clk) check("t5_overflow_clear", overflow, 0);
    @(posedge sys_clk); #1 evt_if.event_ready = 1'b1;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk) check("t5_drained", evt_if.event_valid, 0);

    check("sb_all_consumed", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
